// File: rtl/one_round_permutation_if.sv
// Slice-level bus between the cipher core and the bit-serial Ascon-style permutation.
// The master drives the load, constant and start signals; the slave returns the output slice.
interface one_round_permutation_if;
    logic [4:0] input_data;
    logic       constant;
    logic       start_permutation;
    logic [3:0] iteration;
    logic [4:0] output_data;

    modport master (
        output input_data,
        output constant,
        output start_permutation,
        output iteration,
        input  output_data
    );

    modport slave (
        input  input_data,
        input  constant,
        input  start_permutation,
        input  iteration,
        output output_data
    );
endinterface

// File: rtl/one_round_permutation.sv
// Bit-serial Ascon-style permutation over five 64-bit lanes: serial load, serial
// constant-add plus S-box, one-cycle parallel diffusion, then a serial rotate-out.
module one_round_permutation #(
    parameter bit FIRST_ROUND_LOAD = 1'b1
) (
    input logic                    clk,
    input logic                    rst,
    one_round_permutation_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SBOX = 3'd2,
        LIN  = 3'd3,
        OUT  = 3'd4
    } state_t;

    state_t      state_r;
    logic [63:0] x0_r, x1_r, x2_r, x3_r, x4_r;
    logic [5:0]  bit_cnt_r;
    logic [3:0]  rnd_cnt_r;
    logic [3:0]  rounds_r;

    logic [3:0]  iter_sat_s;
    logic [3:0]  rnd_next_s;
    logic [4:0]  sbox_in_s;
    logic [4:0]  sbox_out_s;

    function automatic logic [4:0] sbox5(input logic [4:0] idx);
        logic [4:0] res;
        case (idx)
            5'h00: res = 5'h04;  5'h01: res = 5'h0b;  5'h02: res = 5'h1f;  5'h03: res = 5'h14;
            5'h04: res = 5'h1a;  5'h05: res = 5'h15;  5'h06: res = 5'h09;  5'h07: res = 5'h02;
            5'h08: res = 5'h1b;  5'h09: res = 5'h05;  5'h0a: res = 5'h08;  5'h0b: res = 5'h12;
            5'h0c: res = 5'h1d;  5'h0d: res = 5'h03;  5'h0e: res = 5'h06;  5'h0f: res = 5'h1c;
            5'h10: res = 5'h1e;  5'h11: res = 5'h13;  5'h12: res = 5'h07;  5'h13: res = 5'h0e;
            5'h14: res = 5'h00;  5'h15: res = 5'h0d;  5'h16: res = 5'h11;  5'h17: res = 5'h18;
            5'h18: res = 5'h10;  5'h19: res = 5'h0c;  5'h1a: res = 5'h01;  5'h1b: res = 5'h19;
            5'h1c: res = 5'h16;  5'h1d: res = 5'h0a;  5'h1e: res = 5'h0f;  5'h1f: res = 5'h17;
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    // Round-count saturation, S-box slice datapath and round-counter increment
    always_comb begin
        iter_sat_s = bus.iteration;
        if (bus.iteration > 4'd12) begin
            iter_sat_s = 4'd12;
        end else begin
            iter_sat_s = bus.iteration;
        end
        sbox_in_s  = {x0_r[63], x1_r[63], x2_r[63] ^ bus.constant, x3_r[63], x4_r[63]};
        sbox_out_s = sbox5(sbox_in_s);
        rnd_next_s = rnd_cnt_r + 4'd1;
    end

    // Output slice is the lane MSBs while streaming, quiet otherwise
    assign bus.output_data = (state_r == OUT) ? {x0_r[63], x1_r[63], x2_r[63], x3_r[63], x4_r[63]}
                                              : 5'd0;

    // Phase sequencer and lane datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            x0_r      <= 64'd0;
            x1_r      <= 64'd0;
            x2_r      <= 64'd0;
            x3_r      <= 64'd0;
            x4_r      <= 64'd0;
            bit_cnt_r <= 6'd0;
            rnd_cnt_r <= 4'd0;
            rounds_r  <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start_permutation) begin
                        rounds_r  <= iter_sat_s;
                        rnd_cnt_r <= 4'd0;
                        if (FIRST_ROUND_LOAD) begin
                            // The start cycle already captures the first load slice
                            x0_r      <= {x0_r[62:0], bus.input_data[4]};
                            x1_r      <= {x1_r[62:0], bus.input_data[3]};
                            x2_r      <= {x2_r[62:0], bus.input_data[2]};
                            x3_r      <= {x3_r[62:0], bus.input_data[1]};
                            x4_r      <= {x4_r[62:0], bus.input_data[0]};
                            bit_cnt_r <= 6'd1;
                            state_r   <= LOAD;
                        end else begin
                            bit_cnt_r <= 6'd0;
                            state_r   <= (iter_sat_s == 4'd0) ? OUT : SBOX;
                        end
                    end else begin
                        bit_cnt_r <= 6'd0;
                    end
                end
                LOAD: begin
                    x0_r      <= {x0_r[62:0], bus.input_data[4]};
                    x1_r      <= {x1_r[62:0], bus.input_data[3]};
                    x2_r      <= {x2_r[62:0], bus.input_data[2]};
                    x3_r      <= {x3_r[62:0], bus.input_data[1]};
                    x4_r      <= {x4_r[62:0], bus.input_data[0]};
                    bit_cnt_r <= bit_cnt_r + 6'd1;
                    if (bit_cnt_r == 6'd63) begin
                        state_r <= (rounds_r == 4'd0) ? OUT : SBOX;
                    end else begin
                        state_r <= LOAD;
                    end
                end
                SBOX: begin
                    x0_r      <= {x0_r[62:0], sbox_out_s[4]};
                    x1_r      <= {x1_r[62:0], sbox_out_s[3]};
                    x2_r      <= {x2_r[62:0], sbox_out_s[2]};
                    x3_r      <= {x3_r[62:0], sbox_out_s[1]};
                    x4_r      <= {x4_r[62:0], sbox_out_s[0]};
                    bit_cnt_r <= bit_cnt_r + 6'd1;
                    state_r   <= (bit_cnt_r == 6'd63) ? LIN : SBOX;
                end
                LIN: begin
                    x0_r      <= x0_r ^ {x0_r[18:0], x0_r[63:19]} ^ {x0_r[27:0], x0_r[63:28]};
                    x1_r      <= x1_r ^ {x1_r[60:0], x1_r[63:61]} ^ {x1_r[38:0], x1_r[63:39]};
                    x2_r      <= x2_r ^ {x2_r[0],    x2_r[63:1]}  ^ {x2_r[5:0],  x2_r[63:6]};
                    x3_r      <= x3_r ^ {x3_r[9:0],  x3_r[63:10]} ^ {x3_r[16:0], x3_r[63:17]};
                    x4_r      <= x4_r ^ {x4_r[6:0],  x4_r[63:7]}  ^ {x4_r[40:0], x4_r[63:41]};
                    rnd_cnt_r <= rnd_next_s;
                    bit_cnt_r <= 6'd0;
                    state_r   <= (rnd_next_s == rounds_r) ? OUT : SBOX;
                end
                OUT: begin
                    // Rotating keeps the final state intact for continuation runs
                    x0_r      <= {x0_r[62:0], x0_r[63]};
                    x1_r      <= {x1_r[62:0], x1_r[63]};
                    x2_r      <= {x2_r[62:0], x2_r[63]};
                    x3_r      <= {x3_r[62:0], x3_r[63]};
                    x4_r      <= {x4_r[62:0], x4_r[63]};
                    bit_cnt_r <= bit_cnt_r + 6'd1;
                    state_r   <= (bit_cnt_r == 6'd63) ? IDLE : OUT;
                end
                default: begin
                    state_r   <= IDLE;
                    bit_cnt_r <= 6'd0;
                    rnd_cnt_r <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_one_round_permutation.sv
// Directed bench: a load-mode and a continuation-mode instance checked against
// hand constants and a word-parallel reference round.
module tb_one_round_permutation;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    one_round_permutation_if ifa ();
    one_round_permutation_if ifb ();

    one_round_permutation #(.FIRST_ROUND_LOAD(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    one_round_permutation #(.FIRST_ROUND_LOAD(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [4:0] SBOX_TBL [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] ref_round(input logic [319:0] s, input logic [7:0] c);
        logic [63:0] x [5];
        logic [4:0]  v;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64 * i -: 64];
        x[2] = x[2] ^ {56'd0, c};
        for (int b = 0; b < 64; b++) begin
            v = SBOX_TBL[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
            x[0][b] = v[4]; x[1][b] = v[3]; x[2][b] = v[2]; x[3][b] = v[1]; x[4][b] = v[0];
        end
        x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
        x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
        x[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
        x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
        x[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("%s_x%0d", tag, i), obs[319 - 64 * i -: 64], exp[319 - 64 * i -: 64]);
        end
    endtask

    task automatic load_a(input logic [319:0] ld, input logic [3:0] iter, input bit tog);
        ifa.iteration = iter;
        for (int k = 0; k < 64; k++) begin
            ifa.start_permutation = (k == 0) ? 1'b1 : (tog && (k % 2 == 1));
            ifa.input_data = {ld[319 - k], ld[255 - k], ld[191 - k], ld[127 - k], ld[63 - k]};
            if (k == 32) check("load_out_zero", {59'd0, ifa.output_data}, 64'd0);
            step();
        end
        ifa.start_permutation = 1'b0;
        ifa.input_data = 5'd0;
    endtask

    task automatic run_a(input logic [319:0] ld, input logic [3:0] iter, input logic [95:0] cs,
                         input bit tog, output logic [319:0] got);
        int nr;
        nr = (iter > 4'd12) ? 12 : int'(iter);
        load_a(ld, iter, tog);
        for (int r = 0; r < nr; r++) begin
            for (int j = 0; j < 65; j++) begin
                ifa.constant = (j >= 56 && j < 64) ? cs[8 * r + 63 - j] : 1'b0;
                ifa.start_permutation = tog && (j % 2 == 0);
                if (r == nr - 1 && j == 64) check("pre_out_zero", {59'd0, ifa.output_data}, 64'd0);
                step();
            end
        end
        ifa.constant = 1'b0;
        got = '0;
        for (int m = 0; m < 64; m++) begin
            ifa.start_permutation = tog && (m < 62) && (m % 2 == 0);
            got[319 - m] = ifa.output_data[4];
            got[255 - m] = ifa.output_data[3];
            got[191 - m] = ifa.output_data[2];
            got[127 - m] = ifa.output_data[1];
            got[63 - m]  = ifa.output_data[0];
            step();
        end
        ifa.start_permutation = 1'b0;
    endtask

    task automatic run_b(input logic [7:0] c, output logic [319:0] got);
        ifb.iteration = 4'd1;
        ifb.start_permutation = 1'b1;
        step();
        ifb.start_permutation = 1'b0;
        for (int j = 0; j < 65; j++) begin
            ifb.constant = (j >= 56 && j < 64) ? c[63 - j] : 1'b0;
            if (j == 64) check("b_pre_out_zero", {59'd0, ifb.output_data}, 64'd0);
            step();
        end
        ifb.constant = 1'b0;
        got = '0;
        for (int m = 0; m < 64; m++) begin
            got[319 - m] = ifb.output_data[4];
            got[255 - m] = ifb.output_data[3];
            got[191 - m] = ifb.output_data[2];
            got[127 - m] = ifb.output_data[1];
            got[63 - m]  = ifb.output_data[0];
            step();
        end
    endtask

    logic [319:0] s1;
    logic [319:0] got;
    logic [319:0] exp;
    logic [95:0]  cs6;
    logic [95:0]  cs12;
    logic [4:0]   idle_or;

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b1;
        ifa.input_data = 5'd0; ifa.constant = 1'b0; ifa.start_permutation = 1'b0; ifa.iteration = 4'd0;
        ifb.input_data = 5'd0; ifb.constant = 1'b0; ifb.start_permutation = 1'b0; ifb.iteration = 4'd0;
        s1 = {64'h8040_0c06_0000_0000, 64'd0, 64'd0, 64'h0000_0000_1215_3524, 64'hffff_ffff_c089_5e81};
        cs6  = {48'd0, 8'h4b, 8'h5a, 8'h69, 8'h78, 8'h87, 8'h96};
        cs12 = {8'h4b, 8'h5a, 8'h69, 8'h78, 8'h87, 8'h96, 8'ha5, 8'hb4, 8'hc3, 8'hd2, 8'he1, 8'hf0};
        step();
        step();
        check("reset_out_a", {59'd0, ifa.output_data}, 64'd0);
        check("reset_out_b", {59'd0, ifb.output_data}, 64'd0);
        check("reset_state_a", {61'd0, dut_a.state_r}, 64'd0);
        rst = 1'b0;
        step();

        // Zero rounds: the loaded words stream back unchanged
        run_a(s1, 4'd0, 96'd0, 1'b0, got);
        check_state("r0_pass", got, s1);

        // One round on zero state: S(0)=04 sets only x2, which diffusion keeps all-ones
        run_a(320'd0, 4'd1, 96'd0, 1'b0, got);
        check_state("r1_zero", got, {64'd0, 64'd0, 64'hffff_ffff_ffff_ffff, 64'd0, 64'd0});

        // Six rounds with start toggling throughout
        run_a(s1, 4'd6, cs6, 1'b1, got);
        exp = s1;
        for (int r = 0; r < 6; r++) exp = ref_round(exp, cs6[8 * r +: 8]);
        check_state("p6", got, exp);
        idle_or = 5'd0;
        for (int i = 0; i < 70; i++) begin
            idle_or = idle_or | ifa.output_data;
            step();
        end
        check("single_run_idle", {59'd0, idle_or}, 64'd0);

        // Iteration above 12 saturates to 12 rounds
        run_a(s1, 4'd15, cs12, 1'b0, got);
        exp = s1;
        for (int r = 0; r < 12; r++) exp = ref_round(exp, cs12[8 * r +: 8]);
        check_state("p12_sat", got, exp);

        // Reset in the middle of round 2 aborts everything
        load_a(s1, 4'd3, 1'b0);
        for (int j = 0; j < 95; j++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_x0", dut_a.x0_r, 64'd0);
        check("abort_x2", dut_a.x2_r, 64'd0);
        check("abort_x4", dut_a.x4_r, 64'd0);
        check("abort_out", {59'd0, ifa.output_data}, 64'd0);
        check("abort_state", {61'd0, dut_a.state_r}, 64'd0);
        run_a(s1, 4'd0, 96'd0, 1'b0, got);
        check_state("after_abort", got, s1);

        // Continuation instance: two back-to-back single rounds from reset state
        run_b(8'hf0, got);
        exp = ref_round(320'd0, 8'hf0);
        check_state("cont1", got, exp);
        run_b(8'he1, got);
        exp = ref_round(exp, 8'he1);
        check_state("cont2", got, exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/one_round_permutation.md
Name: one_round_permutation

Overview:
- Bit-serial Ascon-style permutation over a 320-bit state held as five 64-bit lanes, x0 to x4.
- The state is loaded 5 bits per cycle (one bit per lane), then `iteration` rounds are applied, then the result is streamed out 5 bits per cycle.
- Each round is constant addition plus the 5-bit S-box, processed serially, followed by a one-cycle parallel linear diffusion.
- Sits in the cipher core between the input formatter (IV/key/nonce) and the absorb/squeeze logic.

Parameters:
- FIRST_ROUND_LOAD, 1: 1 = every start runs a 64-cycle LOAD phase first; 0 = skip LOAD and permute the currently held state (continuation mode).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- input_data  in  5  load slice {x0,x1,x2,x3,x4} bits; bit4 goes to x0; MSB-first per lane.
- constant  in  1  serial round-constant bit, XORed into the x2 bit of the current slice.
- start_permutation  in  1  start request; sampled only in IDLE.
- iteration  in  4  number of rounds (0..12); latched at start.
- output_data  out  5  result slice {x0..x4} MSBs during OUT; 0 otherwise.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, all lanes=0, counters=0, output_data=0. Reset has priority over everything and aborts any phase.
- States: IDLE, LOAD, SBOX, LIN, OUT. A 6-bit bit counter and a 4-bit round counter are kept; `iteration` is latched as R.
- IDLE, start_permutation=1, FIRST_ROUND_LOAD=1:
  - This cycle is load cycle 0: every lane shifts left and input_data[4-k] enters the LSB of lane k.
  - Next state is LOAD with cnt=1.
- IDLE, start_permutation=1, FIRST_ROUND_LOAD=0: go to SBOX, or to OUT if R=0.
- LOAD: shift in one slice per cycle for cnt=1..63. After cycle 63, go to SBOX, or to OUT if R=0. After the full load, the first input bit sits at bit 63 of its lane.
- SBOX, 64 cycles per round:
  - Per cycle: slice s = MSBs of x0..x4; s.x2 ^= constant; s' = S(s); all lanes shift left with s' bits entering the LSBs.
  - The bench drives the round's constant byte MSB-first on SBOX cycles 56..63, so it lands on x2 bits 7..0. `constant` must be 0 on other cycles; the design does not mask it.
- S-box, with x0 as the MSB of the index, index 0..31:
  - 04 0b 1f 14 1a 15 09 02 1b 05 08 12 1d 03 06 1c
  - 1e 13 07 0e 00 0d 11 18 10 0c 01 19 16 0a 0f 17
- LIN, 1 cycle, all lanes in parallel:
  - x0 ^= ror(x0,19) ^ ror(x0,28)
  - x1 ^= ror(x1,61) ^ ror(x1,39)
  - x2 ^= ror(x2,1) ^ ror(x2,6)
  - x3 ^= ror(x3,10) ^ ror(x3,17)
  - x4 ^= ror(x4,7) ^ ror(x4,41)
  - Then increment the round counter. If rounds done = R, go to OUT; else go to SBOX.
- Round length is 65 cycles.
- OUT, 64 cycles:
  - output_data = {x0[63],x1[63],x2[63],x3[63],x4[63]} (combinational from the registers).
  - Lanes rotate left by one each cycle, so the state is intact after 64 cycles.
  - Then go to IDLE.
- Latency: the first output slice is valid 64 + 65·R cycles after the start cycle (LOAD mode).
- start_permutation outside IDLE is ignored. A start asserted in the cycle OUT finishes is seen in the following IDLE cycle.
- R > 12 is treated as 12.
- After OUT, lanes hold the final state; a FIRST_ROUND_LOAD=0 instance restarts from it.

Test Plan:
1. R=0; load x0=8040_0c06_0000_0000, x1=0, x2=0, x3=0000_0000_1215_3524, x4=ffff_ffff_c089_5e81 -> OUT streams exactly these words MSB-first, starting cycle 64 after start.
2. R=1; all-zero load; constant=0 -> S(0)=04, so after LIN: x0=x1=x3=x4=0 and x2=ffff_ffff_ffff_ffff.
3. R=6; the load from scenario 1; per-round constants 96,87,78,69,5a,4b on SBOX cycles 56..63 -> output equals the software Ascon p6 golden model; first slice at cycle 64+390.
4. Assert rst in the middle of SBOX of round 2 -> next cycle all lanes 0, output_data=0, IDLE; a new start loads correctly.
5. Toggle start_permutation during LOAD, SBOX and OUT -> no effect; exactly one run completes.
6. FIRST_ROUND_LOAD=0 instance: run R=1 twice back-to-back with no load -> result equals two chained golden rounds; no LOAD cycles are spent.
